// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-write handshake and serial-line status bundle for uart_tx.
interface uart_tx_if;
  logic [7:0] data;
  logic       wr;
  logic       tx;
  logic       full;
  logic       busy;
  logic       done;

  modport master (output data, output wr, input tx, input full, input busy, input done);
  modport slave  (input data, input wr, output tx, output full, output busy, output done);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1/8N2 serial transmitter, LSB first.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry circular FIFO; otherwise a
// single holding register buffers one byte behind the frame in flight.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic     clk,
  input logic     rst,
  uart_tx_if.slave bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned BIT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Reject illegal parameterisations at elaboration.
  if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_tx: CLKS_PER_BIT out of range");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_pend_q;
  logic             done_q;
  logic             full_q, full_d;
  logic             stop_end;
  logic             bit_end;
  logic             push, pop;
  logic             buf_valid;
  logic [7:0]       buf_head;

  // full is the registered pre-edge view, so a same-cycle pop never admits a write.
  assign push    = bus.wr && !full_q;
  assign bit_end = (clk_cnt_q == CNT_LAST);

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign buf_valid = (occ_q != '0);
  assign buf_head  = mem_q[rd_ptr_q];
  assign full_d    = (occ_d == OCC_W'(FIFO_DEPTH));

  // Occupancy tracks push/pop; simultaneous push and pop leave it unchanged.
  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (!push && pop) occ_d = occ_q - OCC_W'(1);
  end

  // Wrapping read/write pointers and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_d;
    end
  end

  // Storage array, unreset; contents are qualified by occupancy.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data;
  end
`else
  logic       valid_q, valid_d;
  logic [7:0] hold_q;

  // push requires !valid and pop requires valid, so they never coincide.
  assign valid_d   = push ? 1'b1 : (pop ? 1'b0 : valid_q);
  assign buf_valid = valid_q;
  assign buf_head  = hold_q;
  assign full_d    = valid_d;

  // Single holding register with valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (push) hold_q <= bus.data;
    end
  end
`endif

  // Framing FSM next-state; line outputs are computed from the current state and registered.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    stop_end  = 1'b0;
    tx_d      = 1'b1;
    busy_d    = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (buf_valid) begin
          pop       = 1'b1;
          shift_d   = buf_head;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == BIT_W'(7)) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            stop_end  = 1'b1;
            bit_cnt_d = '0;
            if (buf_valid) begin
              pop     = 1'b1;
              shift_d = buf_head;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; done lags the last stop clock by the tx pipeline stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_pend_q <= stop_end;
      done_q      <= done_pend_q;
      full_q      <= full_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.full = full_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, timing, buffering and reset.
module tb_uart_tx;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [7:0] seq [5];
  int         nseq;

  uart_tx_if b0 ();
  uart_tx_if b1 ();

  uart_tx u0 (.clk(clk), .rst(rst), .bus(b0));
  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u1 (.clk(clk), .rst(rst), .bus(b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected line for default config: cycle c is edges after the accepting write edge.
  function automatic logic exp_tx(input int c);
    int f;
    int j;
    if (c < 2) return 1'b1;
    f = (c - 2) / 10;
    j = (c - 2) % 10;
    if (f >= nseq) return 1'b1;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return seq[f][j-1];
  endfunction

  function automatic logic exp_busy(input int c);
    return (c >= 2) && (c < 2 + 10 * nseq);
  endfunction

  function automatic logic exp_done(input int c);
    return (c >= 12) && (((c - 2) % 10) == 0) && (c <= 2 + 10 * nseq);
  endfunction

  task automatic step(input int c);
    @(posedge clk);
    #1;
    chk($sformatf("tx@%0d", c), b0.tx, exp_tx(c));
    chk($sformatf("busy@%0d", c), b0.busy, exp_busy(c));
    chk($sformatf("done@%0d", c), b0.done, exp_done(c));
  endtask

  initial begin
    logic [9:0] a5_line;
    n_checks = 0;
    n_fail   = 0;
    nseq     = 0;
    a5_line  = 10'b11_0100_1010;
    rst = 1'b1;
    b0.wr = 1'b0; b0.data = 8'h00;
    b1.wr = 1'b0; b1.data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", b0.tx, 1'b1);
    chk("rst_full", b0.full, 1'b0);
    chk("rst_busy", b0.busy, 1'b0);
    chk("rst_done", b0.done, 1'b0);
    chk("rst_tx1", b1.tx, 1'b1);
    rst = 1'b0;

    // 0xA5, default config: line 0,1,0,1,0,0,1,0,1,1 from edge N+2, done at N+12.
    nseq = 1; seq[0] = 8'hA5;
    b0.data = 8'hA5; b0.wr = 1'b1;
    step(0);
    b0.wr = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      step(c);
      if (c >= 2 && c <= 11) chk($sformatf("a5_hand@%0d", c), b0.tx, a5_line[c-2]);
    end

    // Reset mid-frame forces the line idle without waiting for a clock.
    nseq = 1; seq[0] = 8'h3C;
    b0.data = 8'h3C; b0.wr = 1'b1;
    step(0);
    b0.wr = 1'b0;
    for (int c = 1; c <= 4; c++) step(c);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx", b0.tx, 1'b1);
    chk("async_rst_busy", b0.busy, 1'b0);
    chk("async_rst_full", b0.full, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean frame after reset, nothing left over from the aborted one.
    nseq = 1; seq[0] = 8'h5A;
    b0.data = 8'h5A; b0.wr = 1'b1;
    step(0);
    b0.wr = 1'b0;
    for (int c = 1; c <= 13; c++) step(c);

    // CLKS_PER_BIT=4, STOP_BITS=2, 0x80: 32 low clocks, then 12 high, 44 total.
    b1.data = 8'h80; b1.wr = 1'b1;
    @(posedge clk);
    #1;
    b1.wr = 1'b0;
    @(posedge clk);
    #1;
    chk("slow_pre_tx", b1.tx, 1'b1);
    for (int i = 0; i < 44; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("slow_tx@%0d", i), b1.tx, (i >= 32));
      chk($sformatf("slow_busy@%0d", i), b1.busy, 1'b1);
      chk($sformatf("slow_done@%0d", i), b1.done, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("slow_done_pulse", b1.done, 1'b1);
    chk("slow_busy_end", b1.busy, 1'b0);
    chk("slow_tx_idle", b1.tx, 1'b1);
    @(posedge clk);
    #1;
    chk("slow_done_clear", b1.done, 1'b0);

`ifdef UART_TX_FIFO_EN
    // Prime a frame, then write five bytes timed so the fifth meets full.
    nseq = 5;
    seq[0] = 8'hFF; seq[1] = 8'h01; seq[2] = 8'h02; seq[3] = 8'h03; seq[4] = 8'h04;
    b0.data = 8'hFF; b0.wr = 1'b1;
    step(0);
    b0.wr = 1'b0;
    for (int c = 1; c <= 6; c++) step(c);
    b0.wr = 1'b1;
    b0.data = 8'h01; step(7);  chk("fifo_full@7", b0.full, 1'b0);
    b0.data = 8'h02; step(8);  chk("fifo_full@8", b0.full, 1'b0);
    b0.data = 8'h03; step(9);  chk("fifo_full@9", b0.full, 1'b0);
    b0.data = 8'h04; step(10); chk("fifo_full@10", b0.full, 1'b1);
    b0.data = 8'h05; step(11); chk("fifo_full@11", b0.full, 1'b0);
    b0.wr = 1'b0;
    for (int c = 12; c <= 53; c++) step(c);
`else
    // Holding register: 0x22 fits after the first pop, 0x33 is dropped.
    nseq = 2; seq[0] = 8'h11; seq[1] = 8'h22;
    b0.data = 8'h11; b0.wr = 1'b1;
    step(0); chk("hold_full@0", b0.full, 1'b1);
    b0.wr = 1'b0;
    step(1); chk("hold_full@1", b0.full, 1'b0);
    b0.data = 8'h22; b0.wr = 1'b1;
    step(2); chk("hold_full@2", b0.full, 1'b1);
    b0.data = 8'h33;
    step(3); chk("hold_full@3", b0.full, 1'b1);
    b0.wr = 1'b0;
    for (int c = 4; c <= 23; c++) begin
      step(c);
      if (c == 10) chk("hold_full@10", b0.full, 1'b1);
      if (c == 11) chk("hold_full@11", b0.full, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter feeding the `uart_rx` stage's `rx` input. It accepts bytes over a write-strobe handshake into a small transmit buffer and serializes each byte as:

- one start bit (0);
- 8 data bits, LSB first;
- `STOP_BITS` stop bits (1).

Each bit lasts `CLKS_PER_BIT` clocks. With defaults, one bit per clock, which matches a receiver that samples once per clock.

## Interface
Parameters:
- `CLKS_PER_BIT`, 1, clocks per serial bit; legal range 1..65535.
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2.
- `FIFO_DEPTH`, 4, buffer entries (power of two, ≥2); used only when `UART_TX_FIFO_EN` is defined.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `data`  input  8  byte to transmit; sampled when `wr` is accepted.
- `wr`  input  1  write strobe; accepted on a rising edge where `wr && !full`.
- `tx`  output  1  serial line, registered; idle high.
- `full`  output  1  buffer cannot accept a write this cycle.
- `busy`  output  1  a frame is on the line (start, data or stop phase).
- `done`  output  1  one-cycle pulse in the cycle after a frame's last stop-bit clock.

## Operation
- Reset values: `tx`=1, `full`=0, `busy`=0, `done`=0, FSM=IDLE, buffer empty, all counters 0.
- Assertion of `rst` forces these values immediately, including mid-frame; the partial frame and all buffered bytes are discarded.
- Counters:
  - `clk_cnt` counts 0..`CLKS_PER_BIT`-1 within a bit.
  - `bit_cnt` counts 0..7 data bits, or 0..`STOP_BITS`-1 stop bits.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - `tx`=1, `busy`=0.
  - If the buffer is non-empty: pop the head into the 8-bit shift register, go to START.
- START:
  - `tx`=0 for `CLKS_PER_BIT` clocks, then go to DATA with `bit_cnt`=0.
- DATA:
  - `tx`=shift[0] for `CLKS_PER_BIT` clocks, then shift right.
  - After bit 7, go to STOP.
- STOP:
  - `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` clocks.
  - On the last clock, pulse `done` next cycle.
  - If the buffer is non-empty, pop and go directly to START, with no idle gap. Otherwise go to IDLE.
- Write handling:
  - A write while `full`=1 is dropped; buffer and FSM are unchanged.
  - A write and a pop in the same cycle: the pop frees space for the next cycle, not this one. `full` is evaluated on pre-edge state.
  - A write to an empty buffer in the same cycle the FSM would pop: the byte is seen on the following cycle.
- Frame length: (9+`STOP_BITS`)×`CLKS_PER_BIT` clocks; 10 with defaults.

## Timing
- Write accepted at edge N with FSM in IDLE and buffer empty:
  - the entry is valid after edge N;
  - pop at edge N+1;
  - `tx` falls after edge N+2.
  - Write-to-start-bit latency is 2 clocks.
- `busy` rises together with the start bit and falls with the return to IDLE. `busy` stays 1 across back-to-back frames.
- `done` is high exactly one cycle per completed frame. It coincides with the next start bit when frames are back-to-back.
- `full` is registered and updates the cycle after the push or pop that changes occupancy.
- `tx` is glitch-free (driven by a flop); bit boundaries align to `clk` edges.

## Configuration
- `UART_TX_FIFO_EN` defined:
  - buffer is a `FIFO_DEPTH`-entry circular FIFO with wrapping read/write pointers;
  - `full` is asserted when occupancy equals `FIFO_DEPTH`.
  - Up to `FIFO_DEPTH` bytes can be queued behind the frame in flight.
- `UART_TX_FIFO_EN` undefined:
  - buffer is a single holding register plus valid bit; `full` = valid.
  - Loading the shift register clears valid, so one byte can wait while another transmits.
  - `FIFO_DEPTH` is ignored.

## Test plan
- Reset, defaults → `tx`=1, `full`=0, `busy`=0, `done`=0. Assert `rst` mid-frame → `tx` returns to 1 asynchronously; a subsequent frame starts cleanly.
- Write 0xA5 at edge N, defaults → `tx` sequence from N+2: 0,1,0,1,0,0,1,0,1,1; `done` pulses at N+12. A connected `uart_rx` reports `data`=0xA5 with `ready`=1.
- FIFO on, depth 4:
  - Write 0x01,0x02,0x03,0x04,0x05 on five consecutive edges → first four accepted; `full`=1 for one cycle after the fourth push; 0x05 dropped.
  - Four frames follow back-to-back with no idle bits; `busy` is continuous; four `done` pulses.
- `CLKS_PER_BIT`=4, `STOP_BITS`=2, write 0x80 → start bit low for 4 clocks; seven 0s then one 1, each 4 clocks wide; stop high for 8 clocks. Frame length 44 clocks.
- FIFO off:
  - Write 0x11, then 0x22 one cycle after the first pop → 0x22 accepted, `full`=1.
  - Write 0x33 while `full` → dropped.
  - Line carries 0x11 then 0x22 only.
